// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path.
package rf_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t           rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant with a registered priority pointer.
// The pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, gidx;
  logic          found;
  logic [PW:0]   s;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    s     = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
      idx = s[PW-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Every grant goes to a valid requester, so a grant is always a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (found) ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register-file write port, with a pending-write
// scoreboard used by issue logic for RAW/WAW hazard detection.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  reg_addr_t [NUM_REQ-1:0]        req_rd_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data_i,
  input  logic                           issue_en_i,
  input  reg_addr_t                      issue_rd_i,
  output logic                           issue_ready_o,
  input  logic                           flush_i,
  input  reg_addr_t                      rs1_addr_i,
  input  reg_addr_t                      rs2_addr_i,
  output logic                           rs1_busy_o,
  output logic                           rs2_busy_o,
  output logic                           wr_en_o,
  output reg_addr_t                      rd_addr_o,
  output logic [XLEN-1:0]                rd_data_o,
  output logic [NUM_REGS-1:0]            busy_o
);
  logic                xfer;
  reg_addr_t           sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic                commit_hit, issue_set;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid_i),
    .grant (req_ready_o)
  );

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) begin
        sel_rd   = req_rd_i[i];
        sel_data = req_data_i[i];
      end
    end
  end

  assign xfer = |(req_valid_i & req_ready_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (xfer) begin
      wr_en_o   <= (sel_rd != '0);
      rd_addr_o <= sel_rd;
      rd_data_o <= sel_data;
    end else begin
      wr_en_o   <= 1'b0;
    end
  end

  // A register whose write commits this edge can be re-issued now: the old
  // value lands before the new pending write is recorded, so WAW is safe.
  assign commit_hit    = wr_en_o && (rd_addr_o == issue_rd_i);
  assign issue_ready_o = (issue_rd_i == '0) || !busy[issue_rd_i] || commit_hit;
  assign issue_set     = issue_en_i && issue_ready_o && (issue_rd_i != '0);

  always_comb begin
    busy_nxt = busy;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (wr_en_o)   busy_nxt[rd_addr_o]  = 1'b0;
      if (issue_set) busy_nxt[issue_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_o     = busy;
  assign rs1_busy_o = busy[rs1_addr_i];
  assign rs2_busy_o = busy[rs2_addr_i];

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready_o));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stable
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_rd_i[i]) && $stable(req_data_i[i])));
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench: reference model predicts grants and busy bits,
// a monitor matches committed writes against a scoreboard queue.
module tb_rf_wb_arbiter;
  import rf_pkg::*;
  localparam int N  = 3;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_ready;
  reg_addr_t [N-1:0]     req_rd;
  logic [N-1:0][XL-1:0]  req_data;
  logic                  issue_en, issue_ready, flush;
  reg_addr_t             issue_rd, rs1, rs2, rd_addr;
  logic                  rs1_busy, rs2_busy, wr_en;
  logic [XL-1:0]         rd_data;
  logic [31:0]           busy;

  rf_wb_arbiter #(.XLEN(XL), .NUM_REQ(N), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rd_i(req_rd), .req_data_i(req_data),
    .issue_en_i(issue_en), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .flush_i(flush), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .wr_en_o(wr_en), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .busy_o(busy)
  );

  typedef struct {
    wb_req_t w;
    int      cyc;
  } exp_t;

  exp_t expq[$];
  int   total = 0, bad = 0, cyc = 0;

  // reference model state
  int   ptr = 0;
  bit   mbusy[32];
  bit   pw_v = 0;
  int   pw_rd = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wr_en) begin
      if (expq.size() == 0) begin
        chk("spurious_write", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("wr_rd", rd_addr, e.w.rd);
        chk("wr_data", rd_data, e.w.data);
        chk("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic offer(int i, logic [4:0] rd, logic [31:0] d);
    if (!req_valid[i]) begin
      req_valid[i] = 1'b1;
      req_rd[i]    = rd;
      req_data[i]  = d;
    end
  endtask

  // Check combinational outputs against the model, clock once, advance model.
  task automatic step();
    int          g;
    bit          irdy;
    bit          nb[32];
    logic [N-1:0]  eready;
    logic [31:0] mb;
    exp_t        e;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
    eready = '0;
    if (g >= 0) eready[g] = 1'b1;
    chk("ready", req_ready, eready);
    for (int r = 0; r < 32; r++) mb[r] = mbusy[r];
    chk("busy_vec", busy, mb);
    chk("rs1_busy", rs1_busy, mbusy[rs1]);
    chk("rs2_busy", rs2_busy, mbusy[rs2]);
    irdy = (issue_rd == 0) || !mbusy[issue_rd] || (pw_v && pw_rd == int'(issue_rd));
    chk("issue_ready", issue_ready, irdy);
    nb = mbusy;
    if (flush) begin
      for (int r = 0; r < 32; r++) nb[r] = 0;
    end else begin
      if (pw_v) nb[pw_rd] = 0;
      if (issue_en && irdy && issue_rd != 0) nb[issue_rd] = 1;
    end
    if (g >= 0) begin
      if (req_rd[g] != 0) begin
        e.w.rd = req_rd[g];
        e.w.data = req_data[g];
        e.cyc = cyc + 1;
        expq.push_back(e);
      end
      ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    mbusy = nb;
    pw_v  = (g >= 0) && (req_rd[g] != 0);
    pw_rd = (g >= 0) ? int'(req_rd[g]) : 0;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (|req_valid); n++) step();
    chk("drain_valid", req_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_en = 0; issue_rd = 0; flush = 0; rs1 = 0; rs2 = 0;
    for (int r = 0; r < 32; r++) mbusy[r] = 0;
    #3;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // idle after reset
    step();
    chk("idle_wr_en", wr_en, 0);

    // all three requesters continuously valid
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) offer(i, 5'(5 + i), 32'hA000 + i);
      step();
      if (c > 0) chk("stream_wr_en", wr_en, 1);
    end
    drain();
    step();

    // RAW hazard on x9, then requester 1 writes it
    issue_en = 1; issue_rd = 9; step();
    issue_en = 1; rs1 = 9; step();
    issue_en = 0;
    offer(1, 9, 32'hDEAD); step();
    chk("x9_wr_en", wr_en, 1);
    step(); step();

    // rd=0 request: accepted, no write, pointer advances
    offer(0, 0, 32'h1234); step();
    chk("x0_no_write", wr_en, 0);
    for (int i = 0; i < N; i++) offer(i, 5'(10 + i), 32'hB000 + i);
    drain();
    step();

    // set-wins on simultaneous commit and re-issue of x4, then flush
    issue_en = 1; issue_rd = 4; step();
    issue_en = 0; offer(0, 4, 32'h4444); step();
    issue_en = 1; issue_rd = 4; step();
    chk("x4_still_busy", busy[4], 1);
    issue_en = 0; step();
    flush = 1; issue_en = 1; issue_rd = 8; step();
    flush = 0; issue_en = 0;
    chk("flush_busy", busy, 0);
    step();

    // asynchronous reset while a write is in flight
    issue_en = 1; issue_rd = 3; step();
    issue_en = 0; offer(2, 3, 32'h3333); step();
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_busy3", busy[3], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_busy", busy, 0);
    req_valid = '0;
    expq.delete();
    ptr = 0; pw_v = 0;
    for (int r = 0; r < 32; r++) mbusy[r] = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) offer(i, 5'(20 + i), 32'hC000 + i);
    drain();
    step();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) != 0)
          offer(i, 5'($urandom_range(0, 7)), $urandom);
      issue_en = ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      step();
    end
    issue_en = 0; flush = 0;
    drain();
    step(); step();
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
